song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Top-level controller for the song reader datapath.
- Turns raw play/pause and next-song button levels into registered `play`, `reset_play` and `song` controls.
- Reacts to `song_done`, and sequences a clean player reset whenever the song changes or a song ends.
- Sits between the board buttons and the song reader / note player chain.

Parameters:
- NUM_SONGS, 4, number of songs in ROM; legal range 1..4; `song` wraps from NUM_SONGS-1 to 0.
- RST_CYCLES, 2, cycles `reset_play` is held high per player reset; legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset of the whole block.
- play_pause  input  1  debounced button level; each rising edge toggles play/pause.
- next  input  1  debounced button level; each rising edge advances to the next song.
- song_done  input  1  from song reader; high while the current song has finished.
- play  output  1  to song reader/note player; high = advance notes.
- reset_play  output  1  synchronous reset for the reader/player chain.
- song  output  2  song select driven to the reader address MSBs.
- state  output  2  current FSM state code, for LEDs/debug.

Behaviour:
- All outputs are registered.
- Reset values: play=0, reset_play=1, song=0, state=RST_PLAYER.
- Internal state at reset: rst_cnt=RST_CYCLES-1, resume=0.
- Input conditioning:
  - play_pause and next each pass through a 2-flop synchronizer plus an edge register.
  - pp_evt and nx_evt are single-cycle pulses on a rising edge of the synchronized level.
  - Latency from input rise to the state register changing is 3 clk.
  - Holding a button high produces exactly one event.
- State codes: RST_PLAYER=0, PAUSED=1, PLAYING=2, ADVANCE=3.
- RST_PLAYER:
  - reset_play=1, play=0.
  - rst_cnt decrements each cycle.
  - When rst_cnt==0: go to PLAYING if resume=1, else PAUSED.
  - reset_play is high for exactly RST_CYCLES cycles.
- PAUSED:
  - play=0, reset_play=0.
  - nx_evt -> ADVANCE with resume=0.
  - Otherwise pp_evt -> PLAYING.
  - song_done is ignored.
- PLAYING:
  - play=1, reset_play=0.
  - Priority, highest first: nx_evt, then song_done, then pp_evt.
  - nx_evt -> ADVANCE with resume=1.
  - song_done -> end-of-song handling (see Optional Feature).
  - pp_evt -> PAUSED.
- ADVANCE (one cycle):
  - play=0.
  - song <= (song==NUM_SONGS-1) ? 0 : song+1.
  - Load rst_cnt=RST_CYCLES-1, then go to RST_PLAYER.
- Simultaneous pp_evt and nx_evt: nx_evt wins and pp_evt is dropped.
- Events arriving in RST_PLAYER or ADVANCE are dropped (not queued).
- NUM_SONGS=1: song stays 0; ADVANCE still performs the player reset.
- Asynchronous reset mid-song: immediate return to reset values; after RST_CYCLES cycles the block lands in PAUSED on song 0.
- song changes only in ADVANCE, so it is always stable while reset_play is low.

Optional Feature:
- Macro: SONG_SEQ_AUTO_NEXT_EN.
- Defined: song_done in PLAYING -> ADVANCE with resume=1, so playback continues on the next song, wrapping after the last.
- Undefined: song_done in PLAYING -> load rst_cnt, resume=0, go to RST_PLAYER. The same song is rewound and the block ends in PAUSED.

Decomposition:
- Shared package holds:
  - state encoding constants (RST_PLAYER, PAUSED, PLAYING, ADVANCE);
  - SONG_W=2;
  - default NUM_SONGS/RST_CYCLES.
- One natural sub-module: btn_edge (2-flop synchronizer plus rising-edge pulse), instantiated twice for play_pause and next.

Test Plan:
- Reset release, RST_CYCLES=2 -> reset_play high 2 cycles after release, then state=PAUSED, song=0, play=0.
- play_pause 0->1 held for 20 cycles -> play rises exactly 3 clk after the edge; a second rise sets play=0, state=PAUSED.
- In PLAYING with song=3 and NUM_SONGS=4, pulse next -> ADVANCE, song=0, reset_play high 2 cycles, then PLAYING with play=1.
- In PLAYING, assert song_done and an nx_evt in the same cycle -> treated as next: song increments by exactly 1 and the block returns to PLAYING.
- In PLAYING on song=1, assert song_done:
  - macro undefined -> song=1, reset_play pulse, state=PAUSED;
  - macro defined -> song=2, state=PLAYING.
- Assert reset asynchronously while PLAYING on song=2 -> play=0, reset_play=1, song=0 without waiting for a clock edge; next/play_pause edges during RST_PLAYER cause no state change.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// song_sequencer_pkg
// Shared definitions for the song sequencer slice: the FSM state encoding
// (also shown on the debug LEDs), the song select width, the rewind counter
// width and the default song count / player reset length.
// ----------------------------------------------------------------------------
package song_sequencer_pkg;

    localparam int SONG_W         = 2;
    localparam int CNT_W          = 4;
    localparam int DEF_NUM_SONGS  = 4;
    localparam int DEF_RST_CYCLES = 2;

    // Codes are fixed because the state is exported on the LED/debug port.
    typedef enum logic [1:0] {
        RST_PLAYER = 2'd0,
        PAUSED     = 2'd1,
        PLAYING    = 2'd2,
        ADVANCE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/song_sequencer_btn_edge.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// btn_edge
// Brings a debounced button level into the clk domain through a two-flop
// synchronizer and produces a single-cycle pulse on each rising edge of the
// synchronized level. Holding the button high yields exactly one pulse.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   level  in   debounced button level (asynchronous to clk)
//   evt    out  one-cycle pulse on a rising edge of the synchronized level
// ----------------------------------------------------------------------------
module btn_edge
    import song_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two synchronizer stages followed by a history register for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign evt = sync2 & ~prev;

endmodule

// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// song_sequencer
// Top-level controller for the song reader datapath. Converts play/pause and
// next-song button levels into registered play / reset_play / song controls,
// reacts to song_done, and sequences a player reset whenever the song changes
// or a song ends.
//
// Optional feature macro: SONG_SEQ_AUTO_NEXT_EN
//   defined   : song_done while playing advances to the next song and keeps
//               playing.
//   undefined : song_done while playing rewinds the same song and pauses.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   play_pause  in   debounced button level, each rising edge toggles play
//   next        in   debounced button level, each rising edge selects next song
//   song_done   in   high while the current song has finished
//   play        out  high = reader/player advance notes
//   reset_play  out  synchronous reset for the reader/player chain
//   song        out  song select (reader address MSBs)
//   state       out  current FSM state code for LEDs/debug
// ----------------------------------------------------------------------------
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS  = DEF_NUM_SONGS,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_pause,
    input  logic              next,
    input  logic              song_done,
    output logic              play,
    output logic              reset_play,
    output logic [SONG_W-1:0] song,
    output logic [1:0]        state
);

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

    logic pp_evt;
    logic nx_evt;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              resume_q, resume_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              play_q, reset_play_q;

    btn_edge u_pp_edge (
        .clk   (clk),
        .reset (reset),
        .level (play_pause),
        .evt   (pp_evt)
    );

    btn_edge u_nx_edge (
        .clk   (clk),
        .reset (reset),
        .level (next),
        .evt   (nx_evt)
    );

    // Next-state logic. nx_evt always outranks pp_evt, so a simultaneous pair
    // behaves as a song change and the play/pause press is lost. Events that
    // arrive while rewinding or advancing are simply not looked at.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        resume_d  = resume_q;
        song_d    = song_q;
        case (state_q)
            RST_PLAYER: begin
                if (rst_cnt_q == '0) begin
                    state_d = resume_q ? PLAYING : PAUSED;
                end else begin
                    rst_cnt_d = rst_cnt_q - CNT_W'(1);
                end
            end
            PAUSED: begin
                if (nx_evt) begin
                    state_d  = ADVANCE;
                    resume_d = 1'b0;
                end else if (pp_evt) begin
                    state_d = PLAYING;
                end
            end
            PLAYING: begin
                if (nx_evt) begin
                    state_d  = ADVANCE;
                    resume_d = 1'b1;
                end else if (song_done) begin
`ifdef SONG_SEQ_AUTO_NEXT_EN
                    state_d  = ADVANCE;
                    resume_d = 1'b1;
`else
                    state_d   = RST_PLAYER;
                    rst_cnt_d = CNT_LOAD;
                    resume_d  = 1'b0;
`endif
                end else if (pp_evt) begin
                    state_d = PAUSED;
                end
            end
            ADVANCE: begin
                song_d    = (song_q == SONG_LAST) ? '0 : song_q + SONG_W'(1);
                rst_cnt_d = CNT_LOAD;
                state_d   = RST_PLAYER;
            end
            default: begin
                state_d = RST_PLAYER;
            end
        endcase
    end

    // State and output registers. play and reset_play are decoded from the
    // next state so they change on the same edge as the state code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RST_PLAYER;
            rst_cnt_q    <= CNT_LOAD;
            resume_q     <= 1'b0;
            song_q       <= '0;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            resume_q     <= resume_d;
            song_q       <= song_d;
            play_q       <= (state_d == PLAYING);
            reset_play_q <= (state_d == RST_PLAYER);
        end
    end

    assign play       = play_q;
    assign reset_play = reset_play_q;
    assign song       = song_q;
    assign state      = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench for song_sequencer. A behavioural model tracks the
// player mode, rewind countdown, resume flag and song number from the rules
// of the block; every output is compared against it after each clock, plus a
// handful of directed scenario checks and randomized button/song_done traffic.
// ----------------------------------------------------------------------------
module tb_song_sequencer;

    localparam int NUM_SONGS  = 4;
    localparam int RST_CYCLES = 2;

    localparam int M_RST     = 0;
    localparam int M_PAUSED  = 1;
    localparam int M_PLAYING = 2;
    localparam int M_ADVANCE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play_pause = 1'b0;
    logic       next = 1'b0;
    logic       song_done = 1'b0;
    logic       play;
    logic       reset_play;
    logic [1:0] song;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    int m_mode;
    int m_cnt;
    int m_song;
    bit m_resume;
    bit pp_hist [3];
    bit nx_hist [3];

    always #5 clk = ~clk;

    song_sequencer #(
        .NUM_SONGS  (NUM_SONGS),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (play_pause),
        .next       (next),
        .song_done  (song_done),
        .play       (play),
        .reset_play (reset_play),
        .song       (song),
        .state      (state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mode   = M_RST;
        m_cnt    = RST_CYCLES - 1;
        m_resume = 1'b0;
        m_song   = 0;
        for (int i = 0; i < 3; i++) begin
            pp_hist[i] = 1'b0;
            nx_hist[i] = 1'b0;
        end
    endtask

    // One clock of the reference behaviour. A button event is seen two clocks
    // after the level is first sampled high, provided it was low one clock
    // before that.
    task automatic modelStep(input bit pp, input bit nx, input bit sd);
        bit ppe;
        bit nxe;
        ppe = pp_hist[1] && !pp_hist[2];
        nxe = nx_hist[1] && !nx_hist[2];
        pp_hist[2] = pp_hist[1];
        pp_hist[1] = pp_hist[0];
        pp_hist[0] = pp;
        nx_hist[2] = nx_hist[1];
        nx_hist[1] = nx_hist[0];
        nx_hist[0] = nx;
        case (m_mode)
            M_RST: begin
                if (m_cnt == 0) m_mode = m_resume ? M_PLAYING : M_PAUSED;
                else            m_cnt  = m_cnt - 1;
            end
            M_PAUSED: begin
                if (nxe) begin
                    m_mode   = M_ADVANCE;
                    m_resume = 1'b0;
                end else if (ppe) begin
                    m_mode = M_PLAYING;
                end
            end
            M_PLAYING: begin
                if (nxe) begin
                    m_mode   = M_ADVANCE;
                    m_resume = 1'b1;
                end else if (sd) begin
`ifdef SONG_SEQ_AUTO_NEXT_EN
                    m_mode   = M_ADVANCE;
                    m_resume = 1'b1;
`else
                    m_mode   = M_RST;
                    m_cnt    = RST_CYCLES - 1;
                    m_resume = 1'b0;
`endif
                end else if (ppe) begin
                    m_mode = M_PAUSED;
                end
            end
            default: begin
                m_song = (m_song + 1) % NUM_SONGS;
                m_cnt  = RST_CYCLES - 1;
                m_mode = M_RST;
            end
        endcase
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".play"}, 32'(play), (m_mode == M_PLAYING) ? 1 : 0);
        checkOutput({tag, ".reset_play"}, 32'(reset_play), (m_mode == M_RST) ? 1 : 0);
        checkOutput({tag, ".song"}, 32'(song), m_song);
        checkOutput({tag, ".state"}, 32'(state), m_mode);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next
    // falling edge after the model has taken the same rising edge.
    task automatic applyStimulus(input bit pp, input bit nx, input bit sd, input string tag);
        play_pause = pp;
        next       = nx;
        song_done  = sd;
        @(posedge clk);
        modelStep(pp, nx, sd);
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic press(input bit pp, input bit nx, input int hold, input string tag);
        repeat (hold) applyStimulus(pp, nx, 1'b0, tag);
        repeat (RST_CYCLES + 5) applyStimulus(1'b0, 1'b0, 1'b0, tag);
    endtask

    // Reset asserted in the middle of the low clock phase: outputs must
    // respond without any clock edge.
    task automatic asyncReset(input string tag);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        int  guard;
        bit  seen;
        bit  rpp;
        bit  rnx;
        bit  rsd;

        modelReset();
        @(negedge clk);
        checkAll("reset");
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, "release1");
        checkOutput("release_reset_play_held", 32'(reset_play), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, "release2");
        checkOutput("release_state_paused", 32'(state), M_PAUSED);
        checkOutput("release_reset_play_low", 32'(reset_play), 0);

        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, "hold_pp");
            if (!seen && play === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        checkOutput("pp_latency", lat, 3);
        checkOutput("pp_held_single_event", 32'(state), M_PLAYING);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "pp_release");

        press(1'b1, 1'b0, 2, "pp_pause");
        checkOutput("second_pp_paused", 32'(state), M_PAUSED);
        checkOutput("second_pp_play", 32'(play), 0);

        repeat (3) press(1'b0, 1'b1, 2, "nx_paused");
        checkOutput("three_nexts_song", 32'(song), 3);
        press(1'b1, 1'b0, 2, "play_song3");
        press(1'b0, 1'b1, 2, "wrap_next");
        checkOutput("wrap_song", 32'(song), 0);
        checkOutput("wrap_resumes", 32'(state), M_PLAYING);

        applyStimulus(1'b0, 1'b1, 1'b0, "done_nx_a");
        applyStimulus(1'b0, 1'b1, 1'b0, "done_nx_b");
        applyStimulus(1'b0, 1'b1, 1'b1, "done_nx_c");
        press(1'b0, 1'b0, 1, "done_nx_settle");
        checkOutput("done_and_next_song", 32'(song), 1);
        checkOutput("done_and_next_state", 32'(state), M_PLAYING);

        applyStimulus(1'b0, 1'b0, 1'b1, "song_done");
        press(1'b0, 1'b0, 1, "song_done_settle");
`ifdef SONG_SEQ_AUTO_NEXT_EN
        checkOutput("song_done_song", 32'(song), 2);
        checkOutput("song_done_state", 32'(state), M_PLAYING);
`else
        checkOutput("song_done_song", 32'(song), 1);
        checkOutput("song_done_state", 32'(state), M_PAUSED);
`endif

        guard = 0;
        while (m_song != 2 && guard < 8) begin
            press(1'b0, 1'b1, 2, "seek_song2");
            guard++;
        end
        if (m_mode != M_PLAYING) press(1'b1, 1'b0, 2, "seek_play");
        checkOutput("seek_playing_song2", 32'(song), 2);
        asyncReset("async_reset");
        checkOutput("async_play", 32'(play), 0);
        checkOutput("async_reset_play", 32'(reset_play), 1);
        checkOutput("async_song", 32'(song), 0);
        repeat (RST_CYCLES + 2) applyStimulus(1'b0, 1'b0, 1'b0, "async_recover");
        checkOutput("async_lands_paused", 32'(state), M_PAUSED);

        applyStimulus(1'b0, 1'b1, 1'b0, "drop_a");
        applyStimulus(1'b0, 1'b1, 1'b0, "drop_b");
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, "drop_c");
        press(1'b0, 1'b0, 1, "drop_settle");
        checkOutput("drop_pp_in_rst_state", 32'(state), M_PAUSED);
        checkOutput("drop_pp_in_rst_song", 32'(song), 1);

        applyStimulus(1'b1, 1'b1, 1'b0, "both_a");
        press(1'b1, 1'b1, 3, "both_b");
        checkOutput("both_next_wins_state", 32'(state), M_PAUSED);
        checkOutput("both_next_wins_song", 32'(song), 2);

        rpp = 1'b0;
        rnx = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rpp = ~rpp;
            if ($urandom_range(9) == 0) rnx = ~rnx;
            rsd = ($urandom_range(15) == 0);
            if ($urandom_range(499) == 0) asyncReset("rand_areset");
            else applyStimulus(rpp, rnx, rsd, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
